dcache_snoop_agent: RTL and testbench

- Cache-side coherence responder for one data cache; the snooped end of the coherence interface driven by the memory controller.
- Holds MSI state and tags for a direct-mapped, two-word-block dcache. Answers snoops with ccwrite, supplies dirty blocks as two word writes, and applies invalidations.
- Sits between one dcache and its slice of the cache-control interface, one instance per CPU. Stalls the owning cache while a snoop is in progress.

---
 rtl/dcache_snoop_agent.sv | 185 ++++++++++++++++++
 tb/tb_dcache_snoop_agent.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_snoop_agent.sv
// Snoop responder for one direct-mapped, two-word-block dcache: MSI state/tags, ccwrite, dirty-block supply.
// Optional SNOOP_STATS_EN adds saturating snoop hit / writeback / invalidate counters.
module dcache_snoop_agent #(
  parameter int SETS = 16,
  parameter int TAGW = 32 - 3 - $clog2(SETS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ccwait,
  input  logic [31:0]              ccsnoopaddr,
  input  logic                     ccinv,
  input  logic                     dwait,
  output logic                     ccwrite,
  output logic                     snp_dWEN,
  output logic [31:0]              snp_daddr,
  output logic [31:0]              snp_dstore,
  output logic [$clog2(SETS)-1:0]  dat_idx,
  input  logic [31:0]              dat_rdata0,
  input  logic [31:0]              dat_rdata1,
  input  logic                     fill_en,
  input  logic [31:0]              fill_addr,
  input  logic [1:0]               fill_state,
  output logic                     hold,
  output logic [1:0]               line_state,
`ifdef SNOOP_STATS_EN
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_wbs,
  output logic [31:0]              stat_invs,
`endif
  output logic [1:0]               dbg_state
);

  localparam int IW = $clog2(SETS);
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB0  = 2'd1,
    WB1  = 2'd2
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [1:0]        st_q  [SETS];
  logic [TAGW-1:0]   tag_q [SETS];
  logic [IW-1:0]     lat_idx_q;
  logic [TAGW-1:0]   lat_tag_q;
  logic              inv_seen_q;

  logic [IW-1:0]     s_idx, f_idx;
  logic [TAGW-1:0]   s_tag, f_tag;
  logic [1:0]        s_st;
  logic              hit, snp_m, inv_now, wb_done;
  logic              snoop_wr, fill_ok;
  logic [IW-1:0]     snoop_set;
  logic [1:0]        snoop_val;
  logic              unused_addr_bits;

  assign s_idx = ccsnoopaddr[2+IW:3];
  assign s_tag = ccsnoopaddr[31:3+IW];
  assign f_idx = fill_addr[2+IW:3];
  assign f_tag = fill_addr[31:3+IW];
  assign unused_addr_bits = ^{ccsnoopaddr[2:0], fill_addr[2:0]};

  assign s_st    = st_q[s_idx];
  assign hit     = (tag_q[s_idx] == s_tag) && (s_st != ST_I);
  assign snp_m   = ccwait && hit && (s_st == ST_M);
  // A Modified hit always takes the writeback path, which handles ccinv itself.
  assign inv_now = (fsm_q == IDLE) && ccwait && ccinv && hit && !snp_m;

  assign line_state = (tag_q[f_idx] == f_tag) ? st_q[f_idx] : ST_I;
  assign dbg_state  = fsm_q;

  // Handshake: a writeback word is offered while snp_dWEN=1 and is taken on the
  // rising edge where dwait=0; address/data stay stable until then.
  always_comb begin
    fsm_d      = fsm_q;
    ccwrite    = 1'b0;
    snp_dWEN   = 1'b0;
    snp_daddr  = 32'd0;
    snp_dstore = 32'd0;
    dat_idx    = '0;
    hold       = 1'b0;
    wb_done    = 1'b0;
    case (fsm_q)
      IDLE: begin
        hold    = ccwait;
        ccwrite = snp_m;
        if (snp_m) fsm_d = WB0;
      end
      WB0: begin
        hold       = 1'b1;
        ccwrite    = 1'b1;
        snp_dWEN   = 1'b1;
        snp_daddr  = {lat_tag_q, lat_idx_q, 3'b000};
        snp_dstore = dat_rdata0;
        dat_idx    = lat_idx_q;
        if (!dwait) fsm_d = WB1;
      end
      WB1: begin
        hold       = 1'b1;
        ccwrite    = 1'b1;
        snp_dWEN   = 1'b1;
        snp_daddr  = {lat_tag_q, lat_idx_q, 3'b100};
        snp_dstore = dat_rdata1;
        dat_idx    = lat_idx_q;
        if (!dwait) begin
          fsm_d   = IDLE;
          wb_done = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign snoop_wr  = inv_now || wb_done;
  assign snoop_set = inv_now ? s_idx : lat_idx_q;
  assign snoop_val = (inv_now || inv_seen_q || ccinv) ? ST_I : ST_S;
  assign fill_ok   = fill_en && !hold && (fill_state != 2'b11);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q      <= IDLE;
      lat_idx_q  <= '0;
      lat_tag_q  <= '0;
      inv_seen_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      if (fsm_q == IDLE) begin
        if (snp_m) begin
          lat_idx_q  <= s_idx;
          lat_tag_q  <= s_tag;
          inv_seen_q <= ccinv;
        end else begin
          inv_seen_q <= 1'b0;
        end
      end else if (wb_done) begin
        inv_seen_q <= 1'b0;
      end else begin
        inv_seen_q <= inv_seen_q | ccinv;
      end
    end
  end

  // Snoop updates take priority over a fill to the same set; the cache retries.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SETS; i++) begin
        st_q[i]  <= ST_I;
        tag_q[i] <= '0;
      end
    end else begin
      if (snoop_wr) st_q[snoop_set] <= snoop_val;
      if (fill_ok && !(snoop_wr && (snoop_set == f_idx))) begin
        st_q[f_idx]  <= fill_state;
        tag_q[f_idx] <= f_tag;
      end
    end
  end

`ifdef SNOOP_STATS_EN
  logic ccwait_q;
  logic hit_evt, inv_evt;

  // Count a hit once per snoop: on ccwait rising, or when it causes an action.
  assign hit_evt = (fsm_q == IDLE) && ccwait && hit && (!ccwait_q || snp_m || inv_now);
  assign inv_evt = inv_now || (wb_done && (inv_seen_q || ccinv));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ccwait_q  <= 1'b0;
      stat_hits <= 32'd0;
      stat_wbs  <= 32'd0;
      stat_invs <= 32'd0;
    end else begin
      ccwait_q <= ccwait;
      if (hit_evt && (stat_hits != 32'hFFFF_FFFF)) stat_hits <= stat_hits + 32'd1;
      if (wb_done && (stat_wbs  != 32'hFFFF_FFFF)) stat_wbs  <= stat_wbs + 32'd1;
      if (inv_evt && (stat_invs != 32'hFFFF_FFFF)) stat_invs <= stat_invs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_snoop_agent.sv
// Directed bench for dcache_snoop_agent: reset, writebacks, invalidation, aliasing, fill blocking.
module tb_dcache_snoop_agent;

  logic        CLK;
  logic        RST;
  logic        ccwait;
  logic [31:0] ccsnoopaddr;
  logic        ccinv;
  logic        dwait;
  logic        ccwrite;
  logic        snp_dWEN;
  logic [31:0] snp_daddr;
  logic [31:0] snp_dstore;
  logic [3:0]  dat_idx;
  logic [31:0] dat_rdata0;
  logic [31:0] dat_rdata1;
  logic        fill_en;
  logic [31:0] fill_addr;
  logic [1:0]  fill_state;
  logic        hold;
  logic [1:0]  line_state;
  logic [1:0]  dbg_state;
`ifdef SNOOP_STATS_EN
  logic [31:0] stat_hits, stat_wbs, stat_invs;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dcache_snoop_agent dut (
    .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccsnoopaddr(ccsnoopaddr),
    .ccinv(ccinv), .dwait(dwait), .ccwrite(ccwrite), .snp_dWEN(snp_dWEN),
    .snp_daddr(snp_daddr), .snp_dstore(snp_dstore), .dat_idx(dat_idx),
    .dat_rdata0(dat_rdata0), .dat_rdata1(dat_rdata1), .fill_en(fill_en),
    .fill_addr(fill_addr), .fill_state(fill_state), .hold(hold),
    .line_state(line_state),
`ifdef SNOOP_STATS_EN
    .stat_hits(stat_hits), .stat_wbs(stat_wbs), .stat_invs(stat_invs),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic do_fill(input logic [31:0] a, input logic [1:0] s);
    @(negedge CLK);
    fill_en = 1'b1; fill_addr = a; fill_state = s;
    @(negedge CLK);
    fill_en = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; ccwait = 0; ccsnoopaddr = 0; ccinv = 0; dwait = 0;
    fill_en = 0; fill_addr = 0; fill_state = 0;
    dat_rdata0 = 32'hDEADBEEF; dat_rdata1 = 32'hCAFEF00D;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++; if ({ccwrite, snp_dWEN, hold, line_state, dbg_state} !== 7'd0) begin
      n_err++; $display("FAIL rst_ctrl got %b want 0", {ccwrite, snp_dWEN, hold, line_state, dbg_state}); end
    n_cmp++; if ({snp_daddr, snp_dstore, dat_idx} !== 68'd0) begin
      n_err++; $display("FAIL rst_data got %h %h %h want 0", snp_daddr, snp_dstore, dat_idx); end
    @(negedge CLK); RST = 1'b0;
    do_fill(32'h40, 2'b10);
    #1;
    n_cmp++; if (line_state !== 2'b10) begin n_err++; $display("FAIL rst_fill_m got %b want 10", line_state); end
    n_cmp++; if (hold !== 1'b0) begin n_err++; $display("FAIL rst_hold got %b want 0", hold); end
    #1 RST = 1'b1;
    #1;
    n_cmp++; if (line_state !== 2'b00) begin n_err++; $display("FAIL rst_async_line got %b want 00", line_state); end
    n_cmp++; if ({ccwrite, snp_dWEN, hold, snp_daddr, snp_dstore, dat_idx} !== 71'd0) begin
      n_err++; $display("FAIL rst_async_out got %h want 0", {ccwrite, snp_dWEN, hold, snp_daddr, snp_dstore, dat_idx}); end
    @(negedge CLK); RST = 1'b0;
  endtask

  // Snoop 0x4C against a Modified 0x48: two WB0 cycles (dwait=1,1 then 0), one WB1.
  task automatic run_wb(input string nm, input bit pulse_inv, input bit drop_wait, input logic [1:0] exp_final);
    do_fill(32'h48, 2'b10);
    @(negedge CLK);
    ccwait = 1'b1; ccsnoopaddr = 32'h4C; dwait = 1'b1;
    #1;
    n_cmp++; if ({ccwrite, snp_dWEN, hold} !== 3'b101) begin
      n_err++; $display("FAIL %s_idle got ccwrite/dWEN/hold %b want 101", nm, {ccwrite, snp_dWEN, hold}); end
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      ccinv = pulse_inv && (c == 0);
      if (drop_wait) ccwait = 1'b0;
      if (c == 1) dwait = 1'b0;
      #1;
      n_cmp++; if ({dbg_state, snp_dWEN, ccwrite, hold, dat_idx} !== {2'd1, 3'b111, 4'd9}) begin
        n_err++; $display("FAIL %s_wb0_ctrl got %b want 01_111_1001", nm, {dbg_state, snp_dWEN, ccwrite, hold, dat_idx}); end
      n_cmp++; if ({snp_daddr, snp_dstore} !== {32'h48, 32'hDEADBEEF}) begin
        n_err++; $display("FAIL %s_wb0_word got %h/%h want 00000048/deadbeef", nm, snp_daddr, snp_dstore); end
    end
    @(negedge CLK);
    ccinv = 1'b0;
    #1;
    n_cmp++; if ({dbg_state, snp_dWEN, ccwrite, snp_daddr, snp_dstore} !== {2'd2, 2'b11, 32'h4C, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL %s_wb1 got st=%0d we=%b %h/%h want 2 1 0000004c/cafef00d", nm, dbg_state, snp_dWEN, snp_daddr, snp_dstore); end
    @(negedge CLK);
    ccwait = 1'b0;
    #1;
    n_cmp++; if ({dbg_state, snp_dWEN, ccwrite, hold} !== 5'd0) begin
      n_err++; $display("FAIL %s_done got %b want 00000", nm, {dbg_state, snp_dWEN, ccwrite, hold}); end
    fill_addr = 32'h48;
    #1;
    n_cmp++; if (line_state !== exp_final) begin
      n_err++; $display("FAIL %s_final got %b want %b", nm, line_state, exp_final); end
  endtask

  task automatic test_m_writeback;
    run_wb("mwb", 1'b0, 1'b0, 2'b01);
  endtask

  task automatic test_wb_inv;
    run_wb("wbinv", 1'b1, 1'b0, 2'b00);
  endtask

  task automatic test_wb_no_abort;
    run_wb("noabort", 1'b0, 1'b1, 2'b01);
  endtask

  task automatic test_s_inv;
    do_fill(32'h100, 2'b01);
    @(negedge CLK);
    ccwait = 1'b1; ccsnoopaddr = 32'h100; ccinv = 1'b1; fill_addr = 32'h100;
    #1;
    n_cmp++; if ({ccwrite, snp_dWEN, line_state} !== 4'b0001) begin
      n_err++; $display("FAIL sinv_now got %b want 0001", {ccwrite, snp_dWEN, line_state}); end
    @(negedge CLK);
    #1;
    n_cmp++; if ({ccwrite, snp_dWEN, line_state, dbg_state} !== 6'd0) begin
      n_err++; $display("FAIL sinv_after got %b want 000000", {ccwrite, snp_dWEN, line_state, dbg_state}); end
    ccwait = 1'b0; ccinv = 1'b0;
  endtask

  task automatic test_miss_alias;
    do_fill(32'h80, 2'b10);
    @(negedge CLK);
    ccwait = 1'b1; ccsnoopaddr = 32'h880;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if ({ccwrite, snp_dWEN, dbg_state} !== 4'd0) begin
        n_err++; $display("FAIL alias_c%0d got %b want 0000", c, {ccwrite, snp_dWEN, dbg_state}); end
      @(negedge CLK);
    end
    ccwait = 1'b0;
    #1;
    n_cmp++; if (line_state !== 2'b10) begin n_err++; $display("FAIL alias_state got %b want 10", line_state); end
  endtask

  task automatic test_fill_collision;
    do_fill(32'h48, 2'b10);
    @(negedge CLK);
    ccwait = 1'b1; ccsnoopaddr = 32'h48; dwait = 1'b1;
    @(negedge CLK);
    fill_en = 1'b1; fill_addr = 32'h200; fill_state = 2'b01;
    #1;
    n_cmp++; if ({hold, dbg_state} !== 3'b101) begin n_err++; $display("FAIL coll_hold got %b want 101", {hold, dbg_state}); end
    @(negedge CLK);
    fill_en = 1'b0; dwait = 1'b0; ccwait = 1'b0;
    #1;
    n_cmp++; if (line_state !== 2'b00) begin n_err++; $display("FAIL coll_drop got %b want 00", line_state); end
    fill_addr = 32'h80;
    #1;
    n_cmp++; if (line_state !== 2'b10) begin n_err++; $display("FAIL coll_keep got %b want 10", line_state); end
    repeat (2) @(negedge CLK);
    do_fill(32'h200, 2'b01);
    #1;
    n_cmp++; if (line_state !== 2'b01) begin n_err++; $display("FAIL coll_refill got %b want 01", line_state); end
    fill_addr = 32'h80;
    #1;
    n_cmp++; if (line_state !== 2'b00) begin n_err++; $display("FAIL coll_evicted got %b want 00", line_state); end
  endtask

  task automatic test_reset_mid_wb;
    do_fill(32'h48, 2'b10);
    @(negedge CLK);
    ccwait = 1'b1; ccsnoopaddr = 32'h48; dwait = 1'b1;
    @(negedge CLK);
    ccwait = 1'b0;
    #1;
    n_cmp++; if (snp_dWEN !== 1'b1) begin n_err++; $display("FAIL rstwb_pre got %b want 1", snp_dWEN); end
    #1 RST = 1'b1;
    #1;
    n_cmp++; if ({snp_dWEN, dbg_state, line_state, snp_daddr} !== 37'd0) begin
      n_err++; $display("FAIL rstwb_post got %h want 0", {snp_dWEN, dbg_state, line_state, snp_daddr}); end
    @(negedge CLK);
    RST = 1'b0; dwait = 1'b0;
  endtask

  initial begin
    test_reset();
    test_m_writeback();
    test_wb_inv();
    test_wb_no_abort();
    test_s_inv();
    test_miss_alias();
    test_fill_collision();
    test_reset_mid_wb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
